dmem_arbiter: RTL and testbench

//  Shares the single-port data RAM between the pipeline MEM stage (port C) and a debug/loader master (port D).

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the MEM stage (C) and the debug/loader (D).
// Grants are combinational; the loader may lock the RAM for a bounded burst.
module dmem_arbiter #(
  parameter int unsigned CPU_PRIO = 1,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned LOCK_MAX = 64,
  parameter int unsigned ADDR_HI  = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic        dbg_lock,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic [31:0] ram_a,
  output logic [31:0] ram_wd,
  output logic        ram_we,
  input  logic [31:0] ram_rd,
  output logic        err
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [7:0]  WAIT_LIM = 8'(MAX_WAIT);
  localparam logic [15:0] LOCK_LIM = 16'(LOCK_MAX);

  state_t      r_state, w_state_nxt;
  logic        r_last_gnt, w_last_gnt_nxt;
  logic [7:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic [15:0] r_lock_cnt, w_lock_cnt_nxt;
  logic        r_relock_block, w_relock_nxt;
  logic        r_err;

  logic        w_gnt_c, w_gnt_d, w_we, w_oor;
  logic [31:0] w_addr;
  logic [15:0] w_lock_inc;

  // Grant selection; everything is held off while reset is asserted.
  always_comb begin
    w_gnt_c = 1'b0;
    w_gnt_d = 1'b0;
    if (rst_n) begin
      if (r_state == LOCKED) begin
        w_gnt_d = dbg_req;
      end else if (cpu_req && dbg_req) begin
        if (r_wait_cnt == WAIT_LIM)  w_gnt_d = 1'b1;
        else if (CPU_PRIO != 0)      w_gnt_c = 1'b1;
        else if (r_last_gnt)         w_gnt_c = 1'b1;
        else                         w_gnt_d = 1'b1;
      end else begin
        w_gnt_c = cpu_req;
        w_gnt_d = dbg_req;
      end
    end
  end

  always_comb begin
    w_addr = '0;
    w_we   = 1'b0;
    ram_wd = '0;
    if (w_gnt_d) begin
      w_addr = dbg_addr;
      w_we   = dbg_we;
      ram_wd = dbg_wdata;
    end else if (w_gnt_c) begin
      w_addr = cpu_addr;
      w_we   = cpu_we;
      ram_wd = cpu_wdata;
    end
    w_oor     = (w_gnt_c || w_gnt_d) && (|w_addr[31:ADDR_HI]);
    ram_a     = w_addr;
    ram_we    = w_we && !w_oor;
    cpu_ack   = w_gnt_c;
    dbg_ack   = w_gnt_d;
    cpu_rdata = (w_gnt_c && !w_oor) ? ram_rd : '0;
    dbg_rdata = (w_gnt_d && !w_oor) ? ram_rd : '0;
    cpu_stall = cpu_req && !w_gnt_c;
    err       = r_err;
  end

  // The lock-entry cycle counts as the first locked cycle, so a LOCKED cycle
  // whose incremented count reaches LOCK_MAX is the last one.
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_relock_nxt   = r_relock_block && dbg_lock;
    w_lock_inc     = r_lock_cnt + 16'd1;
    w_last_gnt_nxt = w_gnt_d ? 1'b1 : (w_gnt_c ? 1'b0 : r_last_gnt);
    if (!dbg_req || w_gnt_d)       w_wait_cnt_nxt = '0;
    else if (r_wait_cnt != WAIT_LIM) w_wait_cnt_nxt = r_wait_cnt + 8'd1;
    else                           w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      IDLE: begin
        if (w_gnt_d && dbg_lock && !r_relock_block) begin
          if (LOCK_MAX > 1) begin
            w_state_nxt    = LOCKED;
            w_lock_cnt_nxt = 16'd1;
          end else begin
            w_relock_nxt   = 1'b1;
          end
        end
      end
      LOCKED: begin
        w_lock_cnt_nxt = w_lock_inc;
        if (!dbg_lock) begin
          w_state_nxt = IDLE;
        end else if (w_lock_inc == LOCK_LIM) begin
          w_state_nxt  = IDLE;
          w_relock_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_last_gnt     <= 1'b0;
      r_wait_cnt     <= '0;
      r_lock_cnt     <= '0;
      r_relock_block <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_last_gnt     <= w_last_gnt_nxt;
      r_wait_cnt     <= w_wait_cnt_nxt;
      r_lock_cnt     <= w_lock_cnt_nxt;
      r_relock_block <= w_relock_nxt;
      r_err          <= r_err | w_oor;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances (default, round-robin, short lock)
// share one stimulus stream, each with its own RAM model preloaded with word[k]=k in reset.
module tb_dmem_arbiter;

  logic        clk, rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

  logic [31:0] cpu_rdata [3];
  logic        cpu_ack   [3];
  logic        cpu_stall [3];
  logic [31:0] dbg_rdata [3];
  logic        dbg_ack   [3];
  logic [31:0] ram_a     [3];
  logic [31:0] ram_wd    [3];
  logic        ram_we    [3];
  logic [31:0] ram_rd    [3];
  logic        err       [3];

  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  logic [31:0] mem2 [16];

  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter #(.CPU_PRIO(1), .MAX_WAIT(8), .LOCK_MAX(64), .ADDR_HI(14)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata[0]), .cpu_ack(cpu_ack[0]), .cpu_stall(cpu_stall[0]),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata[0]), .dbg_ack(dbg_ack[0]),
    .ram_a(ram_a[0]), .ram_wd(ram_wd[0]), .ram_we(ram_we[0]), .ram_rd(ram_rd[0]),
    .err(err[0]));

  dmem_arbiter #(.CPU_PRIO(0), .MAX_WAIT(8), .LOCK_MAX(64), .ADDR_HI(14)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata[1]), .cpu_ack(cpu_ack[1]), .cpu_stall(cpu_stall[1]),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata[1]), .dbg_ack(dbg_ack[1]),
    .ram_a(ram_a[1]), .ram_wd(ram_wd[1]), .ram_we(ram_we[1]), .ram_rd(ram_rd[1]),
    .err(err[1]));

  dmem_arbiter #(.CPU_PRIO(1), .MAX_WAIT(8), .LOCK_MAX(4), .ADDR_HI(14)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata[2]), .cpu_ack(cpu_ack[2]), .cpu_stall(cpu_stall[2]),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata[2]), .dbg_ack(dbg_ack[2]),
    .ram_a(ram_a[2]), .ram_wd(ram_wd[2]), .ram_we(ram_we[2]), .ram_rd(ram_rd[2]),
    .err(err[2]));

  assign ram_rd[0] = mem0[ram_a[0][5:2]];
  assign ram_rd[1] = mem1[ram_a[1][5:2]];
  assign ram_rd[2] = mem2[ram_a[2][5:2]];

  always @(posedge clk) begin
    if (!rst_n) for (int k = 0; k < 16; k++) mem0[k] <= 32'(k);
    else if (ram_we[0]) mem0[ram_a[0][5:2]] <= ram_wd[0];
  end
  always @(posedge clk) begin
    if (!rst_n) for (int k = 0; k < 16; k++) mem1[k] <= 32'(k);
    else if (ram_we[1]) mem1[ram_a[1][5:2]] <= ram_wd[1];
  end
  always @(posedge clk) begin
    if (!rst_n) for (int k = 0; k < 16; k++) mem2[k] <= 32'(k);
    else if (ram_we[2]) mem2[ram_a[2][5:2]] <= ram_wd[2];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic reset_pulse();
    tick();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h4;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h8;
    #2;
    chk("rst_cpu_ack",   cpu_ack[0],   1'b0);
    chk("rst_dbg_ack",   dbg_ack[0],   1'b0);
    chk("rst_cpu_stall", cpu_stall[0], 1'b1);
    chk("rst_ram_we",    ram_we[0],    1'b0);
    chk("rst_ram_a",     ram_a[0],     32'h0);
    chk("rst_err",       err[0],       1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    clear_inputs();
    cpu_req = 1'b1; cpu_addr = 32'h4;
    #1;
    chk("c_only_ack",   cpu_ack[0],   1'b1);
    chk("c_only_rdata", cpu_rdata[0], 32'h1);
    chk("c_only_stall", cpu_stall[0], 1'b0);
    chk("c_only_ram_a", ram_a[0],     32'h4);

    // Contention: priority instance starves D for 8 cycles, round-robin alternates D-first.
    tick();
    dbg_req = 1'b1; dbg_addr = 32'h8;
    for (int i = 1; i <= 10; i++) begin
      if (i > 1) tick();
      #1;
      chk("prio_cpu_ack", cpu_ack[0], 1'(i != 9));
      chk("prio_dbg_ack", dbg_ack[0], 1'(i == 9));
      if (i == 9) chk("prio_dbg_rdata", dbg_rdata[0], 32'h2);
      if (i <= 4) begin
        chk("rr_dbg_ack", dbg_ack[1], 1'(i % 2 == 1));
        chk("rr_cpu_ack", cpu_ack[1], 1'(i % 2 == 0));
      end
    end

    // Locked burst of writes from the loader.
    tick();
    clear_inputs();
    for (int k = 0; k < 8; k++) begin
      tick();
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_lock = 1'b1;
      dbg_addr = 32'(4 * k); dbg_wdata = 32'hA5;
      cpu_req = (k != 0);
      #1;
      chk("lock_dbg_ack", dbg_ack[0], 1'b1);
      chk("lock_ram_we",  ram_we[0],  1'b1);
      if (k > 0) chk("lock_cpu_stall", cpu_stall[0], 1'b1);
    end
    tick();
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0;
    #1;
    chk("unlock_exit_stall", cpu_stall[0], 1'b1);
    tick();
    #1;
    chk("unlock_cpu_ack", cpu_ack[0], 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick();
      cpu_addr = 32'(4 * k);
      #1;
      chk("burst_readback", cpu_rdata[0], 32'hA5);
    end

    // Forced release after LOCK_MAX=4 and the relock block.
    reset_pulse();
    dbg_req = 1'b1; dbg_lock = 1'b1; cpu_addr = 32'h4;
    #1;
    chk("flock_dbg_ack_1", dbg_ack[2], 1'b1);
    for (int i = 2; i <= 14; i++) begin
      tick();
      cpu_req = 1'b1;
      #1;
      chk("flock_dbg_ack", dbg_ack[2], 1'(i <= 4 || i == 13));
      chk("flock_cpu_ack", cpu_ack[2], 1'(!(i <= 4 || i == 13)));
    end
    tick();
    clear_inputs();
    tick();
    dbg_req = 1'b1; dbg_lock = 1'b1;
    #1;
    chk("relock_dbg_ack", dbg_ack[2], 1'b1);
    tick();
    cpu_req = 1'b1;
    #1;
    chk("relock_dbg_ack_2", dbg_ack[2], 1'b1);
    chk("relock_stall",     cpu_stall[2], 1'b1);

    // Out-of-range accesses and reset in the middle of a lock.
    reset_pulse();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0001_0000; cpu_wdata = 32'hDEAD;
    #1;
    chk("oor_cpu_ack", cpu_ack[0], 1'b1);
    chk("oor_ram_we",  ram_we[0],  1'b0);
    chk("oor_err_now", err[0],     1'b0);
    tick();
    clear_inputs();
    dbg_req = 1'b1; dbg_addr = 32'h0002_0004;
    #1;
    chk("oor_err_next",  err[0],       1'b1);
    chk("oor_dbg_ack",   dbg_ack[0],   1'b1);
    chk("oor_dbg_rdata", dbg_rdata[0], 32'h0);
    tick();
    dbg_req = 1'b0;
    tick();
    #1;
    chk("oor_err_sticky", err[0], 1'b1);
    tick();
    dbg_req = 1'b1; dbg_lock = 1'b1; dbg_addr = 32'h0;
    #1;
    chk("mid_lock_enter", dbg_ack[0], 1'b1);
    tick();
    cpu_req = 1'b1;
    #1;
    chk("mid_lock_stall", cpu_stall[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dbg_ack", dbg_ack[0], 1'b0);
    chk("mid_rst_err",     err[0],     1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle_cpu_ack", cpu_ack[0], 1'b1);
    chk("post_rst_idle_dbg_ack", dbg_ack[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
